// File: rtl/buffer_pkg.sv
// Shared types and line levels for the buffer serial reader.
// The PARITY state is only reachable when BUFFER_SERIAL_READER_PARITY_EN is defined.
package buffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick marks the last cycle of each bit, restart realigns the period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // A tick wraps the period naturally; restart forces a fresh period on state changes.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buffer_serial_reader.sv
// Drains a buffer head-first and sends each word as start/data(LSB first)/stop frames.
// Define BUFFER_SERIAL_READER_PARITY_EN to insert an even-parity bit before STOP.
module buffer_serial_reader
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  head,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   pull,
    output logic                   tx,
    output logic                   busy,
    output logic [15:0]            frames_sent
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bitCnt_q, bitCnt_d;
    logic [15:0]           frames_q, frames_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  restart;

    // Gated by reset so no pop reaches the buffer while the block is held in reset.
    assign pull        = reset && (state_q == IDLE) && enable && (count != '0);
    assign busy        = (state_q != IDLE);
    assign tx          = tx_q;
    assign frames_sent = frames_q;
    assign restart     = (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uBaud (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

`ifdef BUFFER_SERIAL_READER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (pull) begin
            parity_q <= ^head;
        end
    end
`endif

    // tx is computed for the next state so the line changes exactly at bit boundaries.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        frames_d = frames_q;
        tx_d     = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE_LEVEL;
                if (pull) begin
                    state_d  = START;
                    shift_d  = head;
                    bitCnt_d = '0;
                    tx_d     = START_LEVEL;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitCnt_q == LAST_BIT) begin
`ifdef BUFFER_SERIAL_READER_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = STOP_LEVEL;
`endif
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_d[0];
                    end
                end
            end
            PARITY: begin
`ifdef BUFFER_SERIAL_READER_PARITY_EN
                if (tick) begin
                    state_d = STOP;
                    tx_d    = STOP_LEVEL;
                end
`else
                state_d = IDLE;
                tx_d    = TX_IDLE_LEVEL;
`endif
            end
            STOP: begin
                if (tick) begin
                    state_d  = IDLE;
                    frames_d = frames_q + 16'd1;
                    tx_d     = TX_IDLE_LEVEL;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitCnt_q <= '0;
            frames_q <= '0;
            tx_q     <= TX_IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_buffer_serial_reader.sv
// Directed self-checking bench for buffer_serial_reader with a small buffer model.
// Honours BUFFER_SERIAL_READER_PARITY_EN when building expected frames.
module tb_buffer_serial_reader;

    localparam int DW  = 16;
    localparam int CPB = 4;
`ifdef BUFFER_SERIAL_READER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = (DW + 2 + PAR_BITS) * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] head;
    logic [3:0]  count;
    logic        pull;
    logic        tx;
    logic        busy;
    logic [15:0] framesSent;

    logic [15:0] words [0:7];
    logic [7:0]  wrPtr = 8'd0;
    logic [7:0]  rdPtr = 8'd0;
    int          pullCount = 0;
    int          cycleCnt = 0;
    int          lastPull = 0;
    int          prevPull = 0;
    logic        pullPrev = 1'b0;
    logic        doublePull = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          pullBase;

    buffer_serial_reader dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .head       (head),
        .count      (count),
        .pull       (pull),
        .tx         (tx),
        .busy       (busy),
        .frames_sent(framesSent)
    );

    always #5 clock = ~clock;

    assign head  = words[rdPtr[2:0]];
    assign count = 4'(wrPtr - rdPtr);

    // Buffer side: pop on pull and log pull timing for spacing checks.
    always @(posedge clock) begin
        cycleCnt <= cycleCnt + 1;
        pullPrev <= pull;
        if (pull && pullPrev) doublePull <= 1'b1;
        if (pull) begin
            rdPtr     <= rdPtr + 8'd1;
            pullCount <= pullCount + 1;
            prevPull  <= lastPull;
            lastPull  <= cycleCnt;
        end
    end

    task automatic applyStimulus(input logic [15:0] w);
        words[wrPtr[2:0]] = w;
        wrPtr = wrPtr + 8'd1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walks one frame cycle by cycle, expecting start, LSB-first data, optional parity, stop.
    task automatic checkFrame(input string name, input logic [15:0] w);
        int   slot;
        logic expTx;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clock);
            slot = c / CPB;
            if (slot == 0) expTx = 1'b0;
            else if (slot <= DW) expTx = w[slot-1];
            else if (PAR_BITS == 1 && slot == DW + 1) expTx = ^w;
            else expTx = 1'b1;
            checkOutput($sformatf("%s_tx_c%0d", name, c), {31'b0, tx}, {31'b0, expTx});
            if (c == 0 || c == FRAME - 1)
                checkOutput($sformatf("%s_busy_c%0d", name, c), {31'b0, busy}, 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) words[i] = 16'h0000;

        // Held in reset with words waiting
        reset  = 1'b0;
        enable = 1'b1;
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        repeat (3) @(negedge clock);
        checkOutput("rst_tx", {31'b0, tx}, 32'd1);
        checkOutput("rst_pull", {31'b0, pull}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_frames", {16'b0, framesSent}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_pull", {31'b0, pull}, 32'd1);
        enable = 1'b0;
        reset  = 1'b0;
        wrPtr  = rdPtr;
        @(negedge clock);
        reset = 1'b1;

        // Single word A5C3
        @(negedge clock);
        enable = 1'b1;
        applyStimulus(16'hA5C3);
        #1;
        checkOutput("one_pull", {31'b0, pull}, 32'd1);
        checkFrame("one", 16'hA5C3);
        @(negedge clock);
        checkOutput("one_busy_end", {31'b0, busy}, 32'd0);
        checkOutput("one_tx_end", {31'b0, tx}, 32'd1);
        checkOutput("one_pull_end", {31'b0, pull}, 32'd0);
        checkOutput("one_frames", {16'b0, framesSent}, 32'd1);

        // Empty buffer, then disabled with data waiting
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            checkOutput($sformatf("empty_%0d", i), {30'b0, pull, tx}, 32'd1);
        end
        enable = 1'b0;
        applyStimulus(16'h1234);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            checkOutput($sformatf("dis_%0d", i), {30'b0, pull, tx}, 32'd1);
        end
        wrPtr  = rdPtr;
        enable = 1'b1;

        // Back-to-back frames
        @(negedge clock);
        pullBase = pullCount;
        applyStimulus(16'h0001);
        applyStimulus(16'h8000);
        #1;
        checkOutput("b2b_pull0", {31'b0, pull}, 32'd1);
        checkFrame("b2b0", 16'h0001);
        @(negedge clock);
        checkOutput("b2b_gap_busy", {31'b0, busy}, 32'd0);
        checkOutput("b2b_gap_pull", {31'b0, pull}, 32'd1);
        checkOutput("b2b_frames1", {16'b0, framesSent}, 32'd2);
        checkFrame("b2b1", 16'h8000);
        @(negedge clock);
        checkOutput("b2b_busy_end", {31'b0, busy}, 32'd0);
        checkOutput("b2b_pull_end", {31'b0, pull}, 32'd0);
        checkOutput("b2b_frames2", {16'b0, framesSent}, 32'd3);
        checkOutput("b2b_npulls", 32'(pullCount - pullBase), 32'd2);
        checkOutput("b2b_spacing", 32'(lastPull - prevPull), 32'd73);
        checkOutput("b2b_double", {31'b0, doublePull}, 32'd0);

        // Reset while the start bit is on the line
        applyStimulus(16'hBEEF);
        #1;
        checkOutput("rs_pull", {31'b0, pull}, 32'd1);
        @(negedge clock);
        checkOutput("rs_start_tx", {31'b0, tx}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rs_tx", {31'b0, tx}, 32'd1);
        checkOutput("rs_busy", {31'b0, busy}, 32'd0);
        checkOutput("rs_frames", {16'b0, framesSent}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Reset during data bit 5 of FFFF
        @(negedge clock);
        applyStimulus(16'hFFFF);
        #1;
        checkOutput("rd_pull", {31'b0, pull}, 32'd1);
        repeat (25) @(negedge clock);
        checkOutput("rd_busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rd_tx", {31'b0, tx}, 32'd1);
        checkOutput("rd_busy", {31'b0, busy}, 32'd0);
        checkOutput("rd_pull_rst", {31'b0, pull}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(16'h5A3C);
        #1;
        checkOutput("rd_new_pull", {31'b0, pull}, 32'd1);
        checkFrame("rd_new", 16'h5A3C);
        @(negedge clock);
        checkOutput("rd_new_frames", {16'b0, framesSent}, 32'd1);

        // Words with odd and even parity
        applyStimulus(16'h0007);
        applyStimulus(16'h0003);
        #1;
        checkOutput("par_pull0", {31'b0, pull}, 32'd1);
        checkFrame("par7", 16'h0007);
        @(negedge clock);
        checkOutput("par_frames1", {16'b0, framesSent}, 32'd2);
        checkOutput("par_pull1", {31'b0, pull}, 32'd1);
        checkFrame("par3", 16'h0003);
        @(negedge clock);
        checkOutput("par_frames2", {16'b0, framesSent}, 32'd3);
        checkOutput("par_busy_end", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_serial_reader.md
Name: buffer_serial_reader

Overview:
- Consumer end of the team's FIFO `buffer` push/pull interface.
- Drains words from a buffer's head using `pull` and the buffer's occupancy count.
- Sends each word as a framed, bit-serial stream (start, data LSB-first, optional parity, stop) on one output line.
- Sits between a `buffer` instance and an off-block serial link.

Parameters:
- DATA_WIDTH, 16, width of buffer words (matches buffer BUFFER_WIDTH).
- COUNT_WIDTH, 4, width of the buffer occupancy input; must hold values 0..BUFFER_DEPTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥ 1.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = allowed to start new frames.
- head  input  DATA_WIDTH  current buffer head word, combinational from the buffer.
- count  input  COUNT_WIDTH  buffer occupancy; 0 = empty.
- pull  output  1  one-cycle pop strobe to the buffer.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- frames_sent  output  16  completed-frame counter; wraps.

Behaviour:
- Reset (reset=0, async): state IDLE, tx=1, pull=0, busy=0, frames_sent=0. Shift register, bit counter and baud counter all clear.
- Reset mid-frame: tx returns to 1 immediately and the in-flight word is discarded. Buffer state is not touched beyond pulls already issued.
- States and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, busy=0. pull is combinational = (state==IDLE) & enable & (count!=0).
  - In the pull cycle, head is registered into the shift register.
  - At that same edge the buffer advances and the state goes to START.
- pull is never high outside IDLE and never high for 2 consecutive cycles.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. Shift right at each bit boundary. Bit counter counts 0..DATA_WIDTH-1, width $clog2(DATA_WIDTH+1).
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: frames_sent += 1 (mod 2^16), then go to IDLE.
- busy=1 in START, DATA, PARITY and STOP.
- tx is registered; the first START low appears the cycle after pull.
- Frame length: (DATA_WIDTH+2[+1])*CLKS_PER_BIT cycles. Gap between back-to-back frames is exactly 1 clock (the IDLE/pull cycle).
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on every state change. With CLKS_PER_BIT=1 each bit lasts one cycle.
- enable deasserted mid-frame: the current frame completes and no further pull is issued.
- count=0: stay in IDLE, tx=1, pull=0.
- Values of head when count=0 are ignored.
- count decreasing without a pull is a buffer-side error; the block only samples count in IDLE.

Optional Feature:
- Macro BUFFER_SERIAL_READER_PARITY_EN.
- Defined: a PARITY state between DATA and STOP sends the even-parity bit (XOR of the data word) for CLKS_PER_BIT cycles. Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Shared package buffer_pkg:
  - state typedef for IDLE/START/DATA/PARITY/STOP;
  - constants TX_IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- Sub-module baud_tick_gen: parameter CLKS_PER_BIT; inputs clock, reset, restart; output tick.
  - tick is high on the last cycle of each bit period.
  - restart reloads the counter.

Test Plan:
- Reset: hold reset=0 with count=3, enable=1 -> tx=1, pull=0, busy=0, frames_sent=0. Release -> pull=1 on the first cycle.
- Single word, parity off, CLKS_PER_BIT=4: head=16'hA5C3, count=1 -> pull for 1 cycle.
  - Next cycle tx=0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, 4 cycles each.
  - Then tx=1 for 4 cycles; frames_sent=1 after 72 cycles.
- Empty/disabled: count=0 or enable=0 for 200 cycles -> pull never asserted, tx constantly 1.
- Back-to-back: count=2, words 16'h0001 then 16'h8000 -> exactly 2 pulls spaced 73 cycles apart; 1 idle cycle between frames; frames_sent=2.
- Reset mid-DATA: assert reset at bit 5 of 16'hFFFF -> tx=1 in the same cycle (async), busy=0.
  - After release with count=1: new frame starts and sends the new head.
- Parity on (BUFFER_SERIAL_READER_PARITY_EN): head=16'h0007 -> parity bit 1 after data, then stop; frame = 76 cycles. With head=16'h0003 the parity bit is 0.
